// File: rtl/rvb_bextdep_iter_if.sv
// Valid/ready operand and result channel of the iterative bext/bdep unit.
interface rvb_bextdep_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic [XLEN-1:0] din_rs2;
  logic            din_insn3;
  logic            din_insn13;
  logic            din_insn14;
  logic            din_insn30;
  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;

  // Requester side: offers operations, consumes results.
  modport master (
    output din_valid, din_rs1, din_rs2, din_insn3, din_insn13, din_insn14, din_insn30,
    output dout_ready,
    input  din_ready, dout_valid, dout_rd
  );

  // Execution unit side.
  modport slave (
    input  din_valid, din_rs1, din_rs2, din_insn3, din_insn13, din_insn14, din_insn30,
    input  dout_ready,
    output din_ready, dout_valid, dout_rd
  );
endinterface

// File: rtl/rvb_bextdep_iter.sv
// Iterative bext/bdep unit: scans the mask BPC bits per cycle with a fixed,
// data-independent latency of W/BPC+1 cycles and holds the result until taken.
module rvb_bextdep_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  rvb_bextdep_iter_if.slave    bus
);

  localparam int unsigned IW = $clog2(XLEN);
  localparam int unsigned KW = IW + 1;
  localparam logic [IW-1:0] LAST_W32  = IW'(32 - BPC);
  localparam logic [IW-1:0] LAST_FULL = IW'(XLEN - BPC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WRAP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] acc_q;
  logic [IW-1:0]   i_q;
  logic [KW-1:0]   k_q;
  logic            dep_q;
  logic            w32_q;
  logic            legal_q;
  logic            valid_q;
  logic [XLEN-1:0] rd_q;

  logic            ready;
  logic            accept;
  logic            last;
  logic            w32_in;
  logic [XLEN-1:0] acc_n;
  logic [KW-1:0]   k_n;
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] result;

  // Ready depends only on state and the consumer, never on din_valid.
  assign ready  = (state_q == IDLE) || ((state_q == DONE) && bus.dout_ready);
  assign accept = ready && bus.din_valid;

  assign bus.din_ready  = ready;
  assign bus.dout_valid = valid_q;
  assign bus.dout_rd    = rd_q;

  // W ops only exist on a 64-bit datapath.
  assign w32_in = (XLEN == 32) ? 1'b1 : bus.din_insn3;

  // Final group index depends on the effective width of the latched op.
  assign last = (i_q == (w32_q ? LAST_W32 : LAST_FULL));

  // One BPC-wide slice of the mask scan, ascending bit order.
  always_comb begin
    acc_n = acc_q;
    k_n   = k_q;
    idx   = '0;
    for (int unsigned j = 0; j < BPC; j++) begin
      idx = i_q + IW'(j);
      if (rs2_q[idx]) begin
        if (dep_q) begin
          acc_n[idx] = rs1_q[k_n[IW-1:0]];
        end else begin
          acc_n[k_n[IW-1:0]] = rs1_q[idx];
        end
        k_n = k_n + KW'(1);
      end
    end
  end

  // Result formatting: illegal funct3 yields zero, W ops sign-extend bit 31.
  always_comb begin
    result = '0;
    if (legal_q) begin
      if (w32_q) begin
        result = XLEN'($signed(acc_q[31:0]));
      end else begin
        result = acc_q;
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      k_q     <= '0;
      dep_q   <= 1'b0;
      w32_q   <= 1'b0;
      legal_q <= 1'b0;
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (accept) begin
        rs1_q   <= bus.din_rs1;
        rs2_q   <= bus.din_rs2;
        dep_q   <= bus.din_insn30;
        w32_q   <= w32_in;
        legal_q <= bus.din_insn14 && bus.din_insn13;
        acc_q   <= '0;
        i_q     <= '0;
        k_q     <= '0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_n;
          k_q   <= k_n;
          i_q   <= i_q + IW'(BPC);
          if (last) begin
            state_q <= WRAP;
          end
        end
        WRAP: begin
          rd_q    <= result;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (bus.dout_ready) begin
            valid_q <= 1'b0;
            state_q <= accept ? BUSY : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
